// File: rtl/frac_tcam_pkg.sv
// Shared types and constants for the fractured LUTRAM TCAM update front end.
package frac_tcam_pkg;

  localparam int SLICE_W = 5;
  localparam int KEYS    = 32;
  localparam int GROUP   = 8;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    PROG,
    FLUSH
  } state_t;

  function automatic int calc_aw(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int calc_groups(input int d);
    return d / GROUP;
  endfunction

  function automatic int calc_gw(input int d);
    return (calc_groups(d) > 1) ? $clog2(calc_groups(d)) : 1;
  endfunction

endpackage

// File: rtl/frac_tcam_updater_if.sv
// Update/search request and result bundle between a requester and frac_tcam_updater.
interface frac_tcam_updater_if #(
  parameter int W = 5,
  parameter int D = 64
);
  localparam int AW = frac_tcam_pkg::calc_aw(D);

  logic          upd_valid;
  logic          upd_ready;
  logic [AW-1:0] upd_addr;
  logic [W-1:0]  upd_value;
  logic [W-1:0]  upd_mask;
  logic          upd_del;
  logic          srch_valid;
  logic          srch_ready;
  logic [W-1:0]  srch_key;
  logic          res_valid;
  logic [D-1:0]  res_match;

  modport master (
    output upd_valid, upd_addr, upd_value, upd_mask, upd_del, srch_valid, srch_key,
    input  upd_ready, srch_ready, res_valid, res_match
  );

  modport slave (
    input  upd_valid, upd_addr, upd_value, upd_mask, upd_del, srch_valid, srch_key,
    output upd_ready, srch_ready, res_valid, res_match
  );
endinterface

// File: rtl/frac_tcam_rule_gen.sv
// Combinational LUT contents for one write group at sweep key k:
// bit i*8+j is 1 when entry j's slice i accepts key k.
module frac_tcam_rule_gen
  import frac_tcam_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [SLICE_W-1:0]          i_k,
  input  logic [GROUP-1:0]            i_valid,
  input  logic [GROUP-1:0][W-1:0]     i_value,
  input  logic [GROUP-1:0][W-1:0]     i_mask,
  output logic [W*GROUP/SLICE_W-1:0]  o_rules
);
  localparam int N = W / SLICE_W;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      for (gj = 0; gj < GROUP; gj++) begin : g_ent
        assign o_rules[gi*GROUP+gj] = i_valid[gj] &&
            (((i_k ^ i_value[gj][gi*SLICE_W +: SLICE_W]) & i_mask[gj][gi*SLICE_W +: SLICE_W]) == '0);
      end
    end
  endgenerate
endmodule

// File: rtl/frac_tcam_updater.sv
// Update/search front end for the fractured LUTRAM TCAM: clears the array, reprograms
// one write group from a shadow copy per update. Optional delete: FRAC_TCAM_UPD_DELETE_EN.
module frac_tcam_updater
  import frac_tcam_pkg::*;
#(
  parameter int W = 5,
  parameter int D = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  frac_tcam_updater_if.slave          bus,
  output logic                        busy,
  output logic [W-1:0]                tcam_sk,
  output logic [D/GROUP-1:0]          tcam_we,
  output logic [W*GROUP/SLICE_W-1:0]  tcam_rules,
  input  logic [D-1:0]                tcam_match
);
  localparam int N  = W / SLICE_W;
  localparam int AW = calc_aw(D);
  localparam int GW = calc_gw(D);
  localparam int RW = N * GROUP;

  state_t              r_state, w_state_next;
  logic [SLICE_W-1:0]  r_k, w_k_next;
  logic [GW-1:0]       r_grp;
  logic [W-1:0]        r_value [D];
  logic [W-1:0]        r_mask  [D];
  logic [D-1:0]        r_valid;
  logic                r_res_valid;
  logic [D-1:0]        r_res_match;

  logic                w_upd_ready, w_srch_ready;
  logic                w_upd_fire, w_srch_fire, w_del;
  logic [GW-1:0]       w_upd_grp;
  logic [GROUP-1:0]    w_grp_valid;
  logic [GROUP-1:0][W-1:0] w_grp_value, w_grp_mask;
  logic [RW-1:0]       w_rules;

`ifdef FRAC_TCAM_UPD_DELETE_EN
  assign w_del = bus.upd_del;
`else
  logic w_unused_del;
  assign w_unused_del = bus.upd_del;
  assign w_del        = 1'b0;
`endif

  assign w_upd_fire  = (r_state == IDLE) && bus.upd_valid;
  assign w_srch_fire = (r_state == IDLE) && !bus.upd_valid && bus.srch_valid;
  assign w_upd_grp   = GW'(bus.upd_addr >> 3);

  // Present the latched group's 8 shadow rules to the rule generator.
  genvar gi;
  generate
    for (gi = 0; gi < GROUP; gi++) begin : g_grp_rd
      logic [AW-1:0] w_idx;
      assign w_idx           = AW'({r_grp, 3'(gi)});
      assign w_grp_valid[gi] = r_valid[w_idx];
      assign w_grp_value[gi] = r_value[w_idx];
      assign w_grp_mask[gi]  = r_mask[w_idx];
    end
  endgenerate

  frac_tcam_rule_gen #(.W(W)) u_rule_gen (
    .i_k     (r_k),
    .i_valid (w_grp_valid),
    .i_value (w_grp_value),
    .i_mask  (w_grp_mask),
    .o_rules (w_rules)
  );

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_upd_ready  = 1'b0;
    w_srch_ready = 1'b0;
    busy         = 1'b1;
    tcam_sk      = '0;
    tcam_we      = '0;
    tcam_rules   = '0;
    case (r_state)
      INIT: begin
        tcam_sk  = {N{r_k}};
        tcam_we  = '1;
        w_k_next = r_k + 1'b1;
        if (r_k == SLICE_W'(KEYS - 1)) w_state_next = FLUSH;
      end
      IDLE: begin
        busy         = 1'b0;
        w_upd_ready  = 1'b1;
        w_srch_ready = !bus.upd_valid;
        tcam_sk      = bus.srch_key;
        if (bus.upd_valid) begin
          w_state_next = PROG;
          w_k_next     = '0;
        end
      end
      PROG: begin
        tcam_sk        = {N{r_k}};
        tcam_we[r_grp] = 1'b1;
        tcam_rules     = w_rules;
        w_k_next       = r_k + 1'b1;
        if (r_k == SLICE_W'(KEYS - 1)) w_state_next = FLUSH;
      end
      // One quiet cycle lets the last LUTRAM write settle before searches resume.
      FLUSH: w_state_next = IDLE;
      default: w_state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= INIT;
      r_k         <= '0;
      r_grp       <= '0;
      r_valid     <= '0;
      r_res_valid <= 1'b0;
      r_res_match <= '0;
    end else begin
      r_state     <= w_state_next;
      r_k         <= w_k_next;
      r_res_valid <= w_srch_fire;
      if (w_srch_fire) r_res_match <= tcam_match;
      if (w_upd_fire) begin
        r_grp                  <= w_upd_grp;
        r_valid[bus.upd_addr]  <= !w_del;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_upd_fire && !w_del) begin
      r_value[bus.upd_addr] <= bus.upd_value;
      r_mask[bus.upd_addr]  <= bus.upd_mask;
    end
  end

  assign bus.upd_ready  = w_upd_ready;
  assign bus.srch_ready = w_srch_ready;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_match  = r_res_match;
endmodule

// File: tb/tb_frac_tcam_updater.sv
// Bench for frac_tcam_updater with a behavioural LUTRAM array and a rule-level reference model.
module tb_frac_tcam_updater;
  localparam int W  = 10;
  localparam int D  = 64;
  localparam int N  = W / 5;
  localparam int G  = D / 8;
  localparam int RW = W * 8 / 5;

  logic          clk, reset, busy;
  logic [W-1:0]  tcam_sk;
  logic [G-1:0]  tcam_we;
  logic [RW-1:0] tcam_rules;
  logic [D-1:0]  tcam_match;

  frac_tcam_updater_if #(.W(W), .D(D)) bus ();

  frac_tcam_updater #(.W(W), .D(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .tcam_sk    (tcam_sk),
    .tcam_we    (tcam_we),
    .tcam_rules (tcam_rules),
    .tcam_match (tcam_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fractured LUTRAM array: each entry slice is a 32x1 table addressed by its key slice.
  logic lut [D][N][32];
  always @(posedge clk) begin
    for (int g = 0; g < G; g++)
      if (tcam_we[g])
        for (int j = 0; j < 8; j++)
          for (int i = 0; i < N; i++)
            lut[g*8+j][i][tcam_sk[i*5 +: 5]] <= tcam_rules[i*8+j];
  end

  always_comb begin
    tcam_match = '1;
    for (int e = 0; e < D; e++)
      for (int i = 0; i < N; i++)
        if (!lut[e][i][tcam_sk[i*5 +: 5]]) tcam_match[e] = 1'b0;
  end

  // Reference: the rule table itself.
  logic         ref_valid [D];
  logic [W-1:0] ref_value [D];
  logic [W-1:0] ref_mask  [D];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [63:0] model_match(input logic [W-1:0] key);
    logic [63:0] r;
    r = '0;
    for (int e = 0; e < D; e++)
      r[e] = ref_valid[e] && (((key ^ ref_value[e]) & ref_mask[e]) == '0);
    return r;
  endfunction

  task automatic model_clear();
    for (int e = 0; e < D; e++) ref_valid[e] = 1'b0;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [W-1:0] v, input logic [W-1:0] m,
                             input logic del);
`ifdef FRAC_TCAM_UPD_DELETE_EN
    if (del) begin
      ref_valid[a] = 1'b0;
      return;
    end
`endif
    ref_valid[a] = 1'b1;
    ref_value[a] = v;
    ref_mask[a]  = m;
  endtask

  task automatic reset_and_init();
    int busy_cnt, we_cnt, t;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    busy_cnt = 0; we_cnt = 0; t = 0;
    while (!bus.upd_ready && t < 100) begin
      if (busy) busy_cnt++;
      if (&tcam_we) we_cnt++;
      @(negedge clk); #1; t++;
    end
    $display("init: busy %0d cycles, we all-ones %0d cycles", busy_cnt, we_cnt);
    check("init_busy_cycles", busy_cnt, 33);
    check("init_we_cycles", we_cnt, 32);
    check("init_upd_ready", bus.upd_ready, 1);
    check("init_srch_ready", bus.srch_ready, 1);
    check("init_res_valid", bus.res_valid, 0);
  endtask

  task automatic do_update(input logic [5:0] a, input logic [W-1:0] v, input logic [W-1:0] m,
                           input logic del);
    int t, cnt;
    logic [G-1:0] oh;
    oh = '0;
    oh[a[5:3]] = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_addr = a; bus.upd_value = v; bus.upd_mask = m; bus.upd_del = del;
    #1;
    t = 0;
    while (!bus.upd_ready && t < 100) begin @(negedge clk); #1; t++; end
    check("upd_accept_ready", bus.upd_ready, 1);
    @(posedge clk);
    model_write(a, v, m, del);
    $display("upd addr=%0d value=%h mask=%h del=%0b", a, v, m, del);
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (cnt == 0) bus.upd_valid = 1'b0;
      #1; cnt++;
      if (cnt == 5)  check("prog_we_onehot", tcam_we, oh);
      if (cnt == 33) check("flush_we_zero", tcam_we, 0);
      if (bus.upd_ready) break;
    end
    check("upd_ready_latency", cnt, 34);
  endtask

  task automatic do_search(input string tag, input logic [W-1:0] key);
    int t;
    logic [63:0] exp;
    exp = model_match(key);
    bus.srch_valid = 1'b1; bus.srch_key = key;
    #1;
    t = 0;
    while (!bus.srch_ready && t < 100) begin @(negedge clk); #1; t++; end
    check({tag, "_ready"}, bus.srch_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.srch_valid = 1'b0;
    #1;
    $display("srch %s key=%h res=%h", tag, key, bus.res_match);
    check({tag, "_res_valid"}, bus.res_valid, 1);
    check(tag, bus.res_match, exp);
    @(negedge clk); #1;
    check({tag, "_pulse_end"}, bus.res_valid, 0);
  endtask

  initial begin
    logic [W-1:0] keys [5];
    logic [63:0]  exp;
    logic [G-1:0] oh;
    int cnt;

    bus.upd_valid = 1'b0; bus.upd_addr = '0; bus.upd_value = '0; bus.upd_mask = '0;
    bus.upd_del = 1'b0; bus.srch_valid = 1'b0; bus.srch_key = '0;

    reset_and_init();
    do_search("empty", 10'h013);

    // Single ternary entry; upper slice is don't-care.
    do_update(6'd5, 10'h014, 10'h01C, 1'b0);
    do_search("e5_hit", 10'h017);
    check("e5_hit_const", bus.res_match, 64'h20);
    do_search("e5_miss", 10'h004);
    check("e5_miss_const", bus.res_match, 64'h0);
`ifdef FRAC_TCAM_UPD_DELETE_EN
    do_update(6'd5, 10'h3FF, 10'h3FF, 1'b1);
    do_search("e5_deleted", 10'h017);
    check("e5_deleted_const", bus.res_match, 64'h0);
`endif

    // Same-group neighbours must survive each other's rewrite.
    do_update(6'd63, 10'h155, 10'h000, 1'b0);
    do_update(6'd60, 10'h00A, 10'h3FF, 1'b0);
    do_search("g7_both", 10'h00A);
    check("g7_both_const", bus.res_match, 64'h9000_0000_0000_0000);
    do_search("g7_wild", 10'h00B);
    check("g7_wild_const", bus.res_match, 64'h8000_0000_0000_0000);

    // Exact match across both slices.
    do_update(6'd8, 10'h2A5, 10'h3FF, 1'b0);
    do_search("e8_hit", 10'h2A5);
    do_search("e8_miss", 10'h2A4);

    // Back-to-back searches, one per cycle.
    for (int i = 0; i < 4; i++) keys[i] = W'($urandom);
    keys[0] = 10'h2A5;
    bus.srch_valid = 1'b1; bus.srch_key = keys[0];
    #1;
    check("b2b_ready", bus.srch_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      exp = model_match(keys[i-1]);
      @(negedge clk);
      if (i < 4) bus.srch_key = keys[i];
      else bus.srch_valid = 1'b0;
      #1;
      $display("srch b2b key=%h res=%h", keys[i-1], bus.res_match);
      check("b2b_res_valid", bus.res_valid, 1);
      check("b2b_res", bus.res_match, exp);
    end
    @(negedge clk); #1;
    check("b2b_pulse_end", bus.res_valid, 0);

    // Update and search together: update wins, search waits.
    bus.upd_valid = 1'b1; bus.upd_addr = 6'd20; bus.upd_value = 10'h0F0; bus.upd_mask = 10'h0F0;
    bus.upd_del = 1'b0; bus.srch_valid = 1'b1; bus.srch_key = 10'h3F5;
    #1;
    check("coll_srch_ready", bus.srch_ready, 0);
    check("coll_upd_ready", bus.upd_ready, 1);
    @(posedge clk);
    model_write(6'd20, 10'h0F0, 10'h0F0, 1'b0);
    exp = model_match(10'h3F5);
    $display("upd addr=20 value=0f0 mask=0f0 with colliding search");
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (cnt == 0) bus.upd_valid = 1'b0;
      #1; cnt++;
      if (bus.res_valid) begin bus.srch_valid = 1'b0; break; end
    end
    $display("srch coll key=3f5 res=%h after %0d cycles", bus.res_match, cnt);
    check("coll_res_latency", cnt, 35);
    check("coll_res", bus.res_match, exp);
    @(negedge clk); #1;
    check("coll_pulse_end", bus.res_valid, 0);

    // Randomised rules with sparse care masks so matches are common.
    for (int it = 0; it < 20; it++) begin
      logic [5:0]   a;
      logic [W-1:0] k;
      a = 6'($urandom);
      do_update(a, W'($urandom), W'($urandom & $urandom), ($urandom_range(0, 7) == 0));
      for (int s = 0; s < 3; s++) begin
        k = W'($urandom);
        if ($urandom_range(0, 1) == 1) k = ref_value[$urandom_range(0, D-1)] ^ W'(1 << $urandom_range(0, W-1));
        do_search("rand", k);
      end
    end

    // Reset in PROG cycle 10 aborts and re-clears the array.
    bus.upd_valid = 1'b1; bus.upd_addr = 6'd42; bus.upd_value = 10'h000; bus.upd_mask = 10'h000;
    #1;
    check("abort_upd_ready", bus.upd_ready, 1);
    @(posedge clk);
    $display("upd addr=42 mask=000 aborted by reset");
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.upd_valid = 1'b0;
    end
    #1;
    oh = '0; oh[5] = 1'b1;
    check("abort_prog_we", tcam_we, oh);
    reset = 1'b1;
    @(negedge clk); #1;
    check("abort_init_we", tcam_we, {G{1'b1}});
    check("abort_busy", busy, 1);
    reset_and_init();
    for (int s = 0; s < 4; s++) begin
      do_search("post_reset", W'($urandom));
      check("post_reset_const", bus.res_match, 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
